// File: rtl/piso_pkg.sv
// Shared types and constants for the piso parallel-in/serial-out transmitter.
package piso_pkg;

  localparam int unsigned AXI4_ADDR_BITS = 32;
  localparam int unsigned AXI4_DATA_BITS = 32;
  localparam int unsigned AXI4_STRB_BITS = AXI4_DATA_BITS / 8;
  localparam int unsigned AXI4_PROT_BITS = 3;
  localparam int unsigned AXI4_RESP_BITS = 2;

  localparam logic [AXI4_ADDR_BITS-1:0] MMIO_BASE_ADDR_DFLT = 32'h4000_0000;

  typedef enum logic {
    IDLE,
    SHIFT
  } piso_state_e;

  // Register select is the word index within the 16-byte window (byte offset / 4)
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_DIV    = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int unsigned STAT_NOT_EMPTY = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_EN        = 2;
  localparam int unsigned STAT_SOFT_RST  = 3;

  localparam logic [AXI4_RESP_BITS-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI4_RESP_BITS-1:0] RESP_SLVERR = 2'b10;

  function automatic logic in_window(input logic [AXI4_ADDR_BITS-1:0] addr,
                                     input logic [AXI4_ADDR_BITS-1:0] base);
    return addr[AXI4_ADDR_BITS-1:4] == base[AXI4_ADDR_BITS-1:4];
  endfunction

endpackage

// File: rtl/piso_fifo.sv
// Single-clock FIFO with wrap-bit pointers, synchronous flush and fill level.
module piso_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/piso.sv
// AXI4-Lite fed parallel-in/serial-out transmitter, LSB first, programmable bit period.
// Optional even parity bit per frame when PISO_PARITY_EN is defined.
module piso
  import piso_pkg::*;
#(
  parameter int unsigned                PISO_WIDTH     = 32,
  parameter int unsigned                PISO_DEPTH     = 16,
  parameter int unsigned                DIV_BITS       = 16,
  parameter logic [AXI4_ADDR_BITS-1:0]  MMIO_BASE_ADDR = MMIO_BASE_ADDR_DFLT
) (
  input  logic                      s_axi4lite_clk,
  input  logic                      s_axi4lite_rstn,
  output logic                      sout,
  output logic                      sout_valid,
  output logic                      s_axi4lite_aw_ready,
  input  logic                      s_axi4lite_aw_valid,
  input  logic [AXI4_ADDR_BITS-1:0] s_axi4lite_aw_addr,
  input  logic [AXI4_PROT_BITS-1:0] s_axi4lite_aw_prot,
  output logic                      s_axi4lite_w_ready,
  input  logic                      s_axi4lite_w_valid,
  input  logic [AXI4_DATA_BITS-1:0] s_axi4lite_w_data,
  input  logic [AXI4_STRB_BITS-1:0] s_axi4lite_w_strb,
  input  logic                      s_axi4lite_b_ready,
  output logic                      s_axi4lite_b_valid,
  output logic [AXI4_RESP_BITS-1:0] s_axi4lite_b_resp,
  output logic                      s_axi4lite_ar_ready,
  input  logic                      s_axi4lite_ar_valid,
  input  logic [AXI4_ADDR_BITS-1:0] s_axi4lite_ar_addr,
  input  logic [AXI4_PROT_BITS-1:0] s_axi4lite_ar_prot,
  input  logic                      s_axi4lite_r_ready,
  output logic                      s_axi4lite_r_valid,
  output logic [AXI4_DATA_BITS-1:0] s_axi4lite_r_data,
  output logic [AXI4_RESP_BITS-1:0] s_axi4lite_r_resp
);

  localparam int unsigned LVL_W = $clog2(PISO_DEPTH) + 1;
  localparam int unsigned CNT_W = $clog2(PISO_WIDTH + 1);
`ifdef PISO_PARITY_EN
  localparam int unsigned LAST_BIT = PISO_WIDTH;
`else
  localparam int unsigned LAST_BIT = PISO_WIDTH - 1;
`endif

  logic clk;
  logic rst_n;
  assign clk   = s_axi4lite_clk;
  assign rst_n = s_axi4lite_rstn;

  // Control/status registers
  logic [DIV_BITS-1:0] div;
  logic                en;
  logic                soft_rstn;

  // AXI capture state
  logic                      aw_held;
  logic                      w_held;
  logic                      rd_req;
  logic [AXI4_ADDR_BITS-1:0] aw_addr_q;
  logic [AXI4_ADDR_BITS-1:0] ar_addr_q;
  logic [AXI4_DATA_BITS-1:0] w_data_q;
  logic                      wr_fire;
  logic                      wr_hit;
  logic                      rd_hit;
  logic [1:0]                wr_sel;
  logic [1:0]                rd_sel;
  logic                      wr_push_req;
  logic [AXI4_DATA_BITS-1:0] rd_word;

  // FIFO interface
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [PISO_WIDTH-1:0] fifo_rdata;
  logic [LVL_W-1:0]      fifo_level;

  // Shifter
  piso_state_e           state, state_n;
  logic [PISO_WIDTH-1:0] shreg, shreg_n;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_n;
  logic [DIV_BITS-1:0]   div_cnt, div_cnt_n;
  logic                  tick;
  logic                  load;
  logic                  cur_bit;

  // Sink for bus fields this block deliberately ignores
  logic unused_bus_fields;
  assign unused_bus_fields = ^{s_axi4lite_aw_prot, s_axi4lite_ar_prot, s_axi4lite_w_strb,
                               aw_addr_q[1:0], ar_addr_q[1:0]};

  assign s_axi4lite_aw_ready = !aw_held && !s_axi4lite_b_valid;
  assign s_axi4lite_w_ready  = !w_held && !s_axi4lite_b_valid;
  assign s_axi4lite_ar_ready = !rd_req && !s_axi4lite_r_valid;

  assign wr_fire     = aw_held && w_held;
  assign wr_hit      = in_window(aw_addr_q, MMIO_BASE_ADDR);
  assign rd_hit      = in_window(ar_addr_q, MMIO_BASE_ADDR);
  assign wr_sel      = aw_addr_q[3:2];
  assign rd_sel      = ar_addr_q[3:2];
  assign wr_push_req = wr_fire && wr_hit && (wr_sel == REG_DATA);
  // full is sampled before any same-cycle pop, so a push while full is always refused
  assign fifo_push   = wr_push_req && soft_rstn && !fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held            <= 1'b0;
      w_held             <= 1'b0;
      aw_addr_q          <= '0;
      w_data_q           <= '0;
      s_axi4lite_b_valid <= 1'b0;
      s_axi4lite_b_resp  <= '0;
      div                <= '0;
      en                 <= 1'b1;
      soft_rstn          <= 1'b1;
    end else begin
      if (s_axi4lite_aw_valid && s_axi4lite_aw_ready) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axi4lite_aw_addr;
      end
      if (s_axi4lite_w_valid && s_axi4lite_w_ready) begin
        w_held   <= 1'b1;
        w_data_q <= s_axi4lite_w_data;
      end
      if (s_axi4lite_b_valid && s_axi4lite_b_ready) s_axi4lite_b_valid <= 1'b0;
      if (wr_fire) begin
        aw_held            <= 1'b0;
        w_held             <= 1'b0;
        s_axi4lite_b_valid <= 1'b1;
        s_axi4lite_b_resp  <= (wr_push_req && !fifo_push) ? RESP_SLVERR : RESP_OKAY;
        if (wr_hit) begin
          case (wr_sel)
            REG_DIV:  div <= w_data_q[DIV_BITS-1:0];
            REG_CTRL: begin
              en        <= w_data_q[0];
              soft_rstn <= w_data_q[1];
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_hit) begin
      case (rd_sel)
        REG_DIV: begin
          rd_word[AXI4_DATA_BITS-1 -: 8] = 8'(fifo_level);
          rd_word[DIV_BITS-1:0]          = div;
        end
        REG_STATUS: begin
          rd_word[STAT_SOFT_RST]  = ~soft_rstn;
          rd_word[STAT_EN]        = en;
          rd_word[STAT_FULL]      = fifo_full;
          rd_word[STAT_NOT_EMPTY] = !fifo_empty;
        end
        REG_CTRL: rd_word[1:0] = {soft_rstn, en};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_req             <= 1'b0;
      ar_addr_q          <= '0;
      s_axi4lite_r_valid <= 1'b0;
      s_axi4lite_r_data  <= '0;
      s_axi4lite_r_resp  <= '0;
    end else begin
      if (s_axi4lite_ar_valid && s_axi4lite_ar_ready) begin
        rd_req    <= 1'b1;
        ar_addr_q <= s_axi4lite_ar_addr;
      end
      if (rd_req) begin
        rd_req             <= 1'b0;
        s_axi4lite_r_valid <= 1'b1;
        s_axi4lite_r_data  <= rd_word;
        s_axi4lite_r_resp  <= RESP_OKAY;
      end else if (s_axi4lite_r_valid && s_axi4lite_r_ready) begin
        s_axi4lite_r_valid <= 1'b0;
      end
    end
  end

  piso_fifo #(
    .WIDTH (PISO_WIDTH),
    .DEPTH (PISO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (!soft_rstn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (w_data_q[PISO_WIDTH-1:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // >= rather than == so shrinking div below the running count ends the bit at once
  assign tick = (div_cnt >= div);

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    div_cnt_n = div_cnt;
    fifo_pop  = 1'b0;
    load      = 1'b0;
    if (!soft_rstn) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (en && !fifo_empty) load = 1'b1;
        end
        SHIFT: begin
          if (!tick) begin
            div_cnt_n = div_cnt + DIV_BITS'(1);
          end else if (bit_cnt == CNT_W'(LAST_BIT)) begin
            if (en && !fifo_empty) load = 1'b1;
            else                   state_n = IDLE;
          end else begin
            div_cnt_n = '0;
            shreg_n   = shreg >> 1;
            bit_cnt_n = bit_cnt + CNT_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
    if (load) begin
      fifo_pop  = 1'b1;
      shreg_n   = fifo_rdata;
      bit_cnt_n = '0;
      div_cnt_n = '0;
      state_n   = SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_cnt_n;
      div_cnt <= div_cnt_n;
    end
  end

`ifdef PISO_PARITY_EN
  logic par;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    par <= 1'b0;
    else if (load) par <= ^fifo_rdata;
  end
  assign cur_bit = (bit_cnt == CNT_W'(PISO_WIDTH)) ? par : shreg[0];
`else
  assign cur_bit = shreg[0];
`endif

  // Registered line outputs; soft reset blanks them one cycle after it is written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sout       <= 1'b0;
      sout_valid <= 1'b0;
    end else begin
      sout_valid <= (state == SHIFT) && soft_rstn;
      sout       <= (state == SHIFT) && soft_rstn && cur_bit;
    end
  end

endmodule

// File: tb/tb_piso.sv
// Directed self-checking bench for piso with a per-word serial scoreboard.
module tb_piso;
  import piso_pkg::*;

  localparam logic [31:0] BASE = MMIO_BASE_ADDR_DFLT;
`ifdef PISO_PARITY_EN
  localparam int FRAME = 33;
`else
  localparam int FRAME = 32;
`endif

  logic                      clk;
  logic                      rst_n;
  logic                      sout;
  logic                      sout_valid;
  logic                      aw_ready, aw_valid;
  logic [AXI4_ADDR_BITS-1:0] aw_addr;
  logic [AXI4_PROT_BITS-1:0] aw_prot;
  logic                      w_ready, w_valid;
  logic [AXI4_DATA_BITS-1:0] w_data;
  logic [AXI4_STRB_BITS-1:0] w_strb;
  logic                      b_ready, b_valid;
  logic [AXI4_RESP_BITS-1:0] b_resp;
  logic                      ar_ready, ar_valid;
  logic [AXI4_ADDR_BITS-1:0] ar_addr;
  logic [AXI4_PROT_BITS-1:0] ar_prot;
  logic                      r_ready, r_valid;
  logic [AXI4_DATA_BITS-1:0] r_data;
  logic [AXI4_RESP_BITS-1:0] r_resp;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  int          mon_bit = 0;
  int          mon_sub = 0;
  int          tb_div = 0;
  int          run = 0;
  int          last_run = 0;
  int          valid_total = 0;

  piso dut (
    .s_axi4lite_clk      (clk),
    .s_axi4lite_rstn     (rst_n),
    .sout                (sout),
    .sout_valid          (sout_valid),
    .s_axi4lite_aw_ready (aw_ready),
    .s_axi4lite_aw_valid (aw_valid),
    .s_axi4lite_aw_addr  (aw_addr),
    .s_axi4lite_aw_prot  (aw_prot),
    .s_axi4lite_w_ready  (w_ready),
    .s_axi4lite_w_valid  (w_valid),
    .s_axi4lite_w_data   (w_data),
    .s_axi4lite_w_strb   (w_strb),
    .s_axi4lite_b_ready  (b_ready),
    .s_axi4lite_b_valid  (b_valid),
    .s_axi4lite_b_resp   (b_resp),
    .s_axi4lite_ar_ready (ar_ready),
    .s_axi4lite_ar_valid (ar_valid),
    .s_axi4lite_ar_addr  (ar_addr),
    .s_axi4lite_ar_prot  (ar_prot),
    .s_axi4lite_r_ready  (r_ready),
    .s_axi4lite_r_valid  (r_valid),
    .s_axi4lite_r_data   (r_data),
    .s_axi4lite_r_resp   (r_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every sout_valid clock pops/compares against the head word
  always @(negedge clk) begin
    logic [31:0] cur;
    logic        exp_bit;
    if (rst_n && sout_valid) begin
      valid_total++;
      run++;
      check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        cur     = exp_q[0];
        exp_bit = (mon_bit < 32) ? cur[mon_bit] : ^cur;
        check("sout_bit", 32'(sout), 32'(exp_bit));
        if (mon_sub >= tb_div) begin
          mon_sub = 0;
          mon_bit++;
          if (mon_bit == FRAME) begin
            exp_q.delete(0);
            mon_bit = 0;
          end
        end else begin
          mon_sub++;
        end
      end
    end else if (run != 0) begin
      last_run = run;
      run      = 0;
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           output logic [1:0] resp);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    int n = 0;
    aw_valid = 1'b1; aw_addr = addr;
    w_valid  = 1'b1; w_data  = data;
    b_ready  = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      if (aw_valid && aw_ready) aw_done = 1'b1;
      if (w_valid && w_ready)   w_done  = 1'b1;
      @(negedge clk);
      n++;
      if (aw_done) aw_valid = 1'b0;
      if (w_done)  w_valid  = 1'b0;
    end
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    check("aw_w_accept", 32'(aw_done && w_done), 32'd1);
    n = 0;
    while (!b_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b_seen", 32'(b_valid), 32'd1);
    resp = b_resp;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
    int n = 0;
    ar_valid = 1'b1; ar_addr = addr; r_ready = 1'b1;
    while (!ar_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    ar_valid = 1'b0;
    n = 0;
    while (!r_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("r_seen", 32'(r_valid), 32'd1);
    data = r_data;
    @(negedge clk);
  endtask

  task automatic wait_drained();
    int n = 0;
    while ((exp_q.size() != 0 || sout_valid) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_mid_word();
    int n = 0;
    while (!(sout_valid && mon_bit >= 8 && mon_bit <= 12) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("mid_word_seen", 32'(sout_valid), 32'd1);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          snap;
    int          n;

    rst_n = 1'b0;
    aw_valid = 1'b0; aw_addr = '0; aw_prot = '0;
    w_valid = 1'b0; w_data = '0; w_strb = '1;
    b_ready = 1'b0;
    ar_valid = 1'b0; ar_addr = '0; ar_prot = '0;
    r_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sout", 32'(sout), 32'd0);
    check("rst_sout_valid", 32'(sout_valid), 32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_r_valid", 32'(r_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    axi_read(BASE + 32'h8, rd);
    check("rst_status", rd, 32'h4);
    axi_read(BASE + 32'h4, rd);
    check("rst_div_fill", rd, 32'h0);

    // div=0, single word: output starts two cycles after the write response
    exp_q.push_back(32'hA5A5_0001);
    axi_write(BASE, 32'hA5A5_0001, resp);
    check("push1_resp", 32'(resp), 32'(RESP_OKAY));
    @(negedge clk);
    check("start_lat1", 32'(sout_valid), 32'd0);
    @(negedge clk);
    check("start_lat2", 32'(sout_valid), 32'd1);
    wait_drained();
    check("run_len_single", 32'(last_run), 32'(FRAME));
    check("idle_after_word", 32'(sout_valid), 32'd0);

    // div=3, two words back to back with every bit held four clocks
    axi_write(BASE + 32'h4, 32'd3, resp);
    tb_div = 3;
    axi_read(BASE + 32'h4, rd);
    check("div_readback", rd, 32'd3);
    exp_q.push_back(32'h1234_5678);
    axi_write(BASE, 32'h1234_5678, resp);
    exp_q.push_back(32'hF0F0_8001);
    axi_write(BASE, 32'hF0F0_8001, resp);
    check("push3_resp", 32'(resp), 32'(RESP_OKAY));
    wait_drained();
    check("run_len_b2b", 32'(last_run), 32'(2 * FRAME * 4));

    // en=0, overfill: 16 accepted, 17th refused
    axi_write(BASE + 32'h4, 32'd0, resp);
    tb_div = 0;
    axi_write(BASE + 32'hC, 32'h2, resp);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(32'hC0DE_0000 + 32'(i) * 32'h0101_0003);
      axi_write(BASE, 32'hC0DE_0000 + 32'(i) * 32'h0101_0003, resp);
      check((i < 16) ? "fill_resp_ok" : "fill_resp_slverr", 32'(resp),
            (i < 16) ? 32'(RESP_OKAY) : 32'(RESP_SLVERR));
    end
    axi_read(BASE + 32'h8, rd);
    check("status_full", rd, 32'h3);
    axi_read(BASE + 32'h4, rd);
    check("fill_level16", rd, 32'h1000_0000);

    // Out-of-window write is ignored, read returns zero
    axi_write(BASE + 32'h100, 32'h55, resp);
    check("oow_resp", 32'(resp), 32'(RESP_OKAY));
    axi_read(BASE + 32'h104, rd);
    check("oow_read", rd, 32'h0);
    axi_read(BASE + 32'h4, rd);
    check("oow_no_push", rd, 32'h1000_0000);

    // Enable, then clear en mid-word: the word completes and nothing new starts
    axi_write(BASE + 32'hC, 32'h3, resp);
    wait_mid_word();
    axi_write(BASE + 32'hC, 32'h2, resp);
    n = 0;
    while (sout_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("en0_word_boundary", 32'(mon_bit), 32'd0);
    snap = valid_total;
    repeat (40) @(negedge clk);
    check("en0_no_restart", 32'(valid_total), 32'(snap));
    axi_read(BASE + 32'h8, rd);
    check("en0_status", rd, 32'h1);

    // Re-enable, then soft reset mid-word: line drops next cycle, FIFO flushed
    axi_write(BASE + 32'hC, 32'h3, resp);
    wait_mid_word();
    axi_write(BASE + 32'hC, 32'h1, resp);
    @(negedge clk);
    check("srst_valid_low", 32'(sout_valid), 32'd0);
    check("srst_sout_low", 32'(sout), 32'd0);
    exp_q.delete();
    mon_bit = 0;
    mon_sub = 0;
    axi_read(BASE + 32'h8, rd);
    check("srst_status", rd, 32'hC);
    axi_write(BASE, 32'hDEAD_BEEF, resp);
    check("srst_push_slverr", 32'(resp), 32'(RESP_SLVERR));
    repeat (5) @(negedge clk);
    check("srst_quiet", 32'(sout_valid), 32'd0);
    axi_write(BASE + 32'hC, 32'h3, resp);
    axi_read(BASE + 32'h8, rd);
    check("srst_release_status", rd, 32'h4);

    // Odd-weight word: parity bit (when built in) is 1
    exp_q.push_back(32'h0000_0007);
    axi_write(BASE, 32'h0000_0007, resp);
    check("push7_resp", 32'(resp), 32'(RESP_OKAY));
    wait_drained();
    check("run_len_parity_word", 32'(last_run), 32'(FRAME));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
